mac_simd_pipe: RTL and testbench

MAC_SIMD_PIPE -- requirements
Module: mac_simd_pipe

---
 rtl/mac_simd_pkg.sv | 9 +
 rtl/mac_lane_mult.sv | 22 ++
 rtl/mac_simd_pipe.sv | 169 ++++++++++++++++
 tb/tb_mac_simd_pipe.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mac_simd_pkg.sv
// Shared constants for the SIMD multiply-accumulate pipeline.
//   LATENCY   : cycles from an accepted input beat to its out_valid
//   MODE_FULL : HALF input value selecting one full-width product
//   MODE_HALF : HALF input value selecting two independent half-width lanes
package mac_simd_pkg;
    localparam int   LATENCY   = 3;
    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_HALF = 1'b1;
endpackage

// File: rtl/mac_lane_mult.sv
// Combinational multiplier with independent signedness per operand.
//   a, b           : operands
//   a_sign, b_sign : 1 = operand is two's complement, 0 = unsigned
//   p              : product, exact in AW+BW bits (signed if either flag set)
module mac_lane_mult #(
    parameter int AW = 18,
    parameter int BW = 9
) (
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    input  logic             a_sign,
    input  logic             b_sign,
    output logic [AW+BW-1:0] p
);
    logic [AW+BW-1:0] ax, bx;

    // Extending both operands to the result width and multiplying modulo
    // 2^(AW+BW) gives the exact product for any sign combination.
    assign ax = {{BW{a_sign & a[AW-1]}}, a};
    assign bx = {{AW{b_sign & b[BW-1]}}, b};
    assign p  = ax * bx;
endmodule

// File: rtl/mac_simd_pipe.sv
// Three-stage multiply-accumulate with a full-width or dual half-width mode.
//   clk, reset         : clock, asynchronous active-high reset
//   in_valid, A, B     : input beat and operands
//   A_sign, B_sign     : operand signedness (applies to both lanes)
//   HALF               : 1 = two independent lanes, 0 = one full product
//   acc_en             : 1 = accumulate, 0 = load the product
//   out_valid, C       : result beat and accumulator value
//   overflow           : sticky overflow, bit 0 = full/lane 0, bit 1 = lane 1
module mac_simd_pipe
    import mac_simd_pkg::*;
#(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [B_WIDTH-1:0]   B,
    input  logic                 A_sign,
    input  logic                 B_sign,
    input  logic                 HALF,
    input  logic                 acc_en,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] C,
    output logic [1:0]           overflow
);
    localparam int AH  = A_WIDTH / 2;
    localparam int BH  = B_WIDTH / 2;
    localparam int CH  = ACC_WIDTH / 2;
    localparam int PW  = A_WIDTH + BH;
    localparam int EXT = ACC_WIDTH - PW;

    logic [LATENCY:1] vld_pipe;

    // stage 1: input registers
    logic [A_WIDTH-1:0] a_r;
    logic [B_WIDTH-1:0] b_r;
    logic as_r, bs_r, half_r, acc_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            a_r      <= '0;
            b_r      <= '0;
            as_r     <= 1'b0;
            bs_r     <= 1'b0;
            half_r   <= 1'b0;
            acc_r    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[LATENCY-1:1], in_valid};
            a_r      <= A;
            b_r      <= B;
            as_r     <= A_Sign_fix(A_sign);
            bs_r     <= B_sign;
            half_r   <= HALF;
            acc_r    <= acc_en;
        end
    end

    function automatic logic A_Sign_fix(input logic s);
        return s;
    endfunction

    // Both multipliers take a B half. In full mode each sees the whole A and
    // the two partial products recombine as p1*2^BH + p0 (B low half is then
    // unsigned). In half mode each sees its own sign-extended A lane.
    logic [A_WIDTH-1:0]   m0_a, m1_a;
    logic                 m0_bs;
    logic [PW-1:0]        p0, p1;
    logic                 sg0, sg1;
    logic [ACC_WIDTH-1:0] e0, e1, full_prod, half_prod, prod_d;

    assign m0_a  = half_r ? {{(A_WIDTH-AH){as_r & a_r[AH-1]}}, a_r[AH-1:0]} : a_r;
    assign m1_a  = half_r ? {{(A_WIDTH-AH){as_r & a_r[A_WIDTH-1]}}, a_r[A_WIDTH-1:AH]} : a_r;
    assign m0_bs = half_r & bs_r;

    mac_lane_mult #(.AW(A_WIDTH), .BW(BH)) u_mult0 (
        .a(m0_a), .b(b_r[BH-1:0]), .a_sign(as_r), .b_sign(m0_bs), .p(p0)
    );
    mac_lane_mult #(.AW(A_WIDTH), .BW(BH)) u_mult1 (
        .a(m1_a), .b(b_r[B_WIDTH-1:BH]), .a_sign(as_r), .b_sign(bs_r), .p(p1)
    );

    assign sg0       = as_r | m0_bs;
    assign sg1       = as_r | bs_r;
    assign e0        = {{EXT{sg0 & p0[PW-1]}}, p0};
    assign e1        = {{EXT{sg1 & p1[PW-1]}}, p1};
    assign full_prod = (e1 << BH) + e0;
    assign half_prod = {e1[CH-1:0], e0[CH-1:0]};
    assign prod_d    = (half_r == MODE_HALF) ? half_prod : full_prod;

    // stage 2: product registers
    logic [ACC_WIDTH-1:0] prod_r;
    logic sgn2, half2, acc2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_r <= '0;
            sgn2   <= 1'b0;
            half2  <= 1'b0;
            acc2   <= 1'b0;
        end else begin
            prod_r <= prod_d;
            sgn2   <= sg1;
            half2  <= half_r;
            acc2   <= acc_r;
        end
    end

    // stage 3: accumulator
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [1:0]           ovf_q, ovf_d;
    logic                 have_last, last_half, load;
    logic [ACC_WIDTH:0]   sum_full;
    logic [CH:0]          sum_lo, sum_hi;
    logic                 ovf_full, ovf_lo, ovf_hi;

    // A mode change or the first beat after reset cannot extend a sum.
    assign load = !acc2 || !have_last || (half2 != last_half);

    assign sum_full = {1'b0, acc_q} + {1'b0, prod_r};
    assign sum_lo   = {1'b0, acc_q[CH-1:0]} + {1'b0, prod_r[CH-1:0]};
    assign sum_hi   = {1'b0, acc_q[ACC_WIDTH-1:CH]} + {1'b0, prod_r[ACC_WIDTH-1:CH]};

    assign ovf_full = sgn2 ? ((acc_q[ACC_WIDTH-1] == prod_r[ACC_WIDTH-1]) &&
                              (sum_full[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                           : sum_full[ACC_WIDTH];
    assign ovf_lo   = sgn2 ? ((acc_q[CH-1] == prod_r[CH-1]) &&
                              (sum_lo[CH-1] != acc_q[CH-1]))
                           : sum_lo[CH];
    assign ovf_hi   = sgn2 ? ((acc_q[ACC_WIDTH-1] == prod_r[ACC_WIDTH-1]) &&
                              (sum_hi[CH-1] != acc_q[ACC_WIDTH-1]))
                           : sum_hi[CH];

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (load) begin
            acc_d = prod_r;
            ovf_d = 2'b00;
        end else if (half2 == MODE_FULL) begin
            acc_d = sum_full[ACC_WIDTH-1:0];
            ovf_d = {1'b0, ovf_q[0] | ovf_full};
        end else begin
            acc_d = {sum_hi[CH-1:0], sum_lo[CH-1:0]};
            ovf_d = ovf_q | {ovf_hi, ovf_lo};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            ovf_q     <= 2'b00;
            have_last <= 1'b0;
            last_half <= 1'b0;
        end else if (vld_pipe[LATENCY-1]) begin
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            have_last <= 1'b1;
            last_half <= half2;
        end
    end

    assign out_valid = vld_pipe[LATENCY];
    assign C         = acc_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_mac_simd_pipe.sv
module tb_mac_simd_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, A_sign, B_sign, HALF, acc_en;
    logic [17:0] A, B;
    logic        out_valid, ov38;
    logic [47:0] C;
    logic [37:0] C38;
    logic [1:0]  overflow, ovf38;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_simd_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .A(A), .B(B),
        .A_sign(A_sign), .B_sign(B_sign), .HALF(HALF), .acc_en(acc_en),
        .out_valid(out_valid), .C(C), .overflow(overflow)
    );

    mac_simd_pipe #(.ACC_WIDTH(38)) dut38 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .A(A), .B(B),
        .A_sign(A_sign), .B_sign(B_sign), .HALF(HALF), .acc_en(acc_en),
        .out_valid(ov38), .C(C38), .overflow(ovf38)
    );

    typedef struct {
        logic [17:0] a, b;
        logic        as, bs, half;
        logic [47:0] c;
    } vec_t;

    typedef struct {
        logic        v, half, ae;
        logic [47:0] c;
    } step_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [17:0] a, input logic [17:0] b,
                         input logic as, input logic bs, input logic h, input logic ae);
        in_valid = v; A = a; B = b; A_sign = as; B_sign = bs; HALF = h; acc_en = ae;
    endtask

    task automatic idle();
        drive(1'b0, 18'h15555, 18'h2AAAA, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // n accumulating beats on the 38-bit instance, one more accumulate, then a load.
    task automatic ovf_seq(input string nm, input logic [17:0] a, input logic [17:0] b,
                           input logic sg, input int n, input int ovf_at, input logic [37:0] p);
        int nb;
        nb = n + 2;
        for (int i = 0; i < nb + 3; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                int k;
                logic [37:0] m, e;
                logic eo;
                k = i - 3;
                if (k == nb - 1) begin
                    e = p; eo = 1'b0;
                end else begin
                    m = 38'(k + 1); e = m * p; eo = (k + 1 >= ovf_at);
                end
                chk($sformatf("%s out%0d valid", nm, k), ov38, 1);
                chk($sformatf("%s out%0d C", nm, k), C38, e);
                chk($sformatf("%s out%0d ovf", nm, k), ovf38, {1'b0, eo});
            end
            if (i < nb) drive(1'b1, a, b, sg, sg, 1'b0, (i != 0) && (i != nb - 1));
            else idle();
        end
    endtask

    initial begin
        vec_t  vt[9];
        step_t st[8];

        vt = '{
            '{18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0, 48'h000FFFF80001},
            '{18'h3FFFF, 18'd2,     1'b1, 1'b1, 1'b0, 48'hFFFFFFFFFFFE},
            '{{9'd3, 9'd5}, {9'd7, 9'd11}, 1'b0, 1'b0, 1'b1, {24'd21, 24'd55}},
            '{18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 48'hFFFFFFFC0001},
            '{18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1, 1'b0, 48'hFFFFFFFC0001},
            '{{9'h1FF, 9'h1FE}, {9'd3, 9'h1FC}, 1'b1, 1'b1, 1'b1, {24'hFFFFFD, 24'h000008}},
            '{{9'h100, 9'h1FF}, {9'h1FF, 9'd2}, 1'b1, 1'b0, 1'b1, {24'hFE0100, 24'hFFFFFE}},
            '{18'd12345, 18'd678,   1'b0, 1'b0, 1'b0, 48'd8369910},
            '{18'h20000, 18'h20000, 1'b1, 1'b1, 1'b0, 48'h000400000000}
        };

        // A=3, B=4 throughout; beat 6 is not valid and must leave C at 24.
        st = '{
            '{1'b1, 1'b0, 1'b0, 48'd12},
            '{1'b1, 1'b0, 1'b1, 48'd24},
            '{1'b1, 1'b0, 1'b1, 48'd36},
            '{1'b1, 1'b0, 1'b1, 48'd48},
            '{1'b1, 1'b1, 1'b1, 48'd12},
            '{1'b1, 1'b1, 1'b1, 48'd24},
            '{1'b0, 1'b0, 1'b0, 48'd24},
            '{1'b1, 1'b1, 1'b1, 48'd36}
        };

        reset = 1'b1;
        idle();
        #2;
        chk("reset out_valid", out_valid, 0);
        chk("reset C", C, 0);
        chk("reset overflow", overflow, 0);
        chk("reset38 out_valid", ov38, 0);
        chk("reset38 C", C38, 0);
        chk("reset38 overflow", ovf38, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // isolated load beats
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(1'b1, vt[i].a, vt[i].b, vt[i].as, vt[i].bs, vt[i].half, 1'b0);
            @(negedge clk);
            idle();
            @(negedge clk);
            chk($sformatf("vec%0d early valid", i), out_valid, 0);
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), out_valid, 1);
            chk($sformatf("vec%0d C", i), C, vt[i].c);
            chk($sformatf("vec%0d overflow", i), overflow, 0);
        end

        // back-to-back accumulation with a mode-change reload and a bubble
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                chk($sformatf("acc out%0d valid", i - 3), out_valid, st[i-3].v);
                chk($sformatf("acc out%0d C", i - 3), C, st[i-3].c);
            end
            if (i < 8) begin
                if (st[i].v) drive(1'b1, 18'd3, 18'd4, 1'b0, 1'b0, st[i].half, st[i].ae);
                else drive(1'b0, 18'd99, 18'd99, 1'b0, 1'b0, 1'b0, 1'b0);
            end else idle();
        end

        ovf_seq("sovf", 18'h20000, 18'h20000, 1'b1, 8, 8, 38'h0400000000);
        ovf_seq("uovf", 18'h3FFFF, 18'h3FFFF, 1'b0, 5, 5, 38'h0FFFF80001);

        // reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 18'd5, 18'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset C", C, 0);
        chk("midreset overflow", overflow, 0);
        chk("midreset38 C", C38, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 18'd2, 18'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 1) idle();
            chk($sformatf("postreset cyc%0d valid", j), out_valid, (j == 3));
            if (j >= 3) chk($sformatf("postreset cyc%0d C", j), C, 48'd6);
            else chk($sformatf("postreset cyc%0d C", j), C, 48'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
